option22_seq_ctrl: RTL and testbench

Word-access sequencer for the option22 recirculating serial shift memory (WORD_COUNT × 8-bit words in one rotating shift chain). Accepts single-word read/write requests over a valid/ready port. Tracks the chain's rotation position and waits for the addressed word to reach the tap. Then, for 8 cycles, it either drives the memory's write/din pins or captures the serial tap into a response byte. It sits between the io_in/io_out wrapper logic and the shift memory, and is reset together with the memory so rotation alignment holds.

---
 rtl/option22_pkg.sv | 23 ++
 rtl/option22_pos_counter.sv | 34 +++
 rtl/option22_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_option22_seq_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/option22_pkg.sv
// Shared definitions for the option22 shift-memory word sequencer.
package option22_pkg;

  // Default memory geometry: 64 words of 8 bits in a single rotating chain.
  localparam int DEF_WORD_COUNT = 64;
  localparam int DEF_CHAIN_LEN  = DEF_WORD_COUNT * 8;
  localparam int DEF_POS_W      = $clog2(DEF_CHAIN_LEN);

  // Controller states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEEK = 3'd1,
    XFER = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } state_t;

  // Chain length in bits for a given word count.
  function automatic int chainLen(input int words);
    return words * 8;
  endfunction

endpackage

// File: rtl/option22_pos_counter.sv
// Free-running rotation position counter for the option22 shift chain.
// Also splits the position into the word currently at the tap and the
// bit index within that word.
module option22_pos_counter
  import option22_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int POS_W     = $clog2(CHAIN_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [POS_W-1:0] o_pos,
  output logic [POS_W-4:0] o_word,
  output logic [2:0]       o_bit
);

  logic [POS_W-1:0] r_pos;

  // Advance one position per cycle, wrapping at the end of the chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos <= '0;
    end else if (r_pos == POS_W'(CHAIN_LEN - 1)) begin
      r_pos <= '0;
    end else begin
      r_pos <= r_pos + 1'b1;
    end
  end

  assign o_pos  = r_pos;
  assign o_word = r_pos[POS_W-1:3];
  assign o_bit  = r_pos[2:0];

endmodule

// File: rtl/option22_seq_ctrl.sv
// Word-access sequencer for the option22 recirculating shift memory.
// Accepts one read or write at a time, waits for the addressed word to
// rotate to the tap, then spends 8 cycles either driving write/din or
// shifting the tap into a capture register, and finally pulses rsp_valid.
module option22_seq_ctrl #(
  parameter int WORD_COUNT = option22_pkg::DEF_WORD_COUNT,
  parameter int ADDR_W     = 6
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_we,
  input  logic [ADDR_W-1:0]                 req_addr,
  input  logic [7:0]                        req_wdata,
  output logic                              rsp_valid,
  output logic                              rsp_err,
  output logic [7:0]                        rsp_rdata,
  output logic                              mem_write,
  output logic                              mem_din,
  input  logic                              mem_dout,
  output logic [$clog2(WORD_COUNT*8)-1:0]   pos
);

  import option22_pkg::*;

  localparam int CHAIN_LEN = chainLen(WORD_COUNT);
  localparam int POS_W     = $clog2(CHAIN_LEN);

  state_t              r_state;
  state_t              w_nextState;

  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_wdata;
  logic [7:0]          r_shift;
  logic [7:0]          r_rspData;
  logic                r_rspErr;

  logic [POS_W-1:0]    w_pos;
  logic [POS_W-4:0]    w_word;
  logic [2:0]          w_bit;

  logic                w_accept;
  logic                w_reqInRange;
  logic                w_arriveReq;
  logic                w_arriveLatched;
  logic [7:0]          w_captured;

  // Word that sits just ahead of the target in the rotation.
  function automatic logic [31:0] predWord(input logic [31:0] a);
    return (a == 32'd0) ? 32'(WORD_COUNT - 1) : (a - 32'd1);
  endfunction

  option22_pos_counter #(
    .CHAIN_LEN (CHAIN_LEN),
    .POS_W     (POS_W)
  ) u_posCounter (
    .clk    (clk),
    .reset  (reset),
    .o_pos  (w_pos),
    .o_word (w_word),
    .o_bit  (w_bit)
  );

  assign pos          = w_pos;
  assign w_accept     = req_valid && (r_state == IDLE);
  assign w_reqInRange = 32'(req_addr) < 32'(WORD_COUNT);

  // The target word reaches the tap next cycle when the last bit of its
  // predecessor is at the tap now. Looking one cycle ahead lets the
  // transfer begin exactly on the cycle pos == 8*addr, and means a match
  // on the accept cycle itself is never taken.
  assign w_arriveReq     = (w_bit == 3'd7) && (32'(w_word) == predWord(32'(req_addr)));
  assign w_arriveLatched = (w_bit == 3'd7) && (32'(w_word) == predWord(32'(r_addr)));

  assign w_captured = {r_shift[6:0], mem_dout};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; SEEK is bypassed when the word arrives right after accept.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (!w_reqInRange) begin
            w_nextState = ERR;
          end else if (w_arriveReq) begin
            w_nextState = XFER;
          end else begin
            w_nextState = SEEK;
          end
        end
      end
      SEEK: begin
        if (w_arriveLatched) begin
          w_nextState = XFER;
        end
      end
      XFER: begin
        if (w_bit == 3'd7) begin
          w_nextState = RESP;
        end
      end
      RESP:    w_nextState = IDLE;
      ERR:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Handshake, response strobe and memory pin drive decoded from the state.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_write = 1'b0;
    mem_din   = 1'b0;
    case (r_state)
      IDLE: req_ready = 1'b1;
      XFER: begin
        if (r_we) begin
          mem_write = 1'b1;
          mem_din   = r_wdata[3'd7 - w_bit];
        end
      end
      RESP: rsp_valid = 1'b1;
      ERR:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request latch, serial capture and held response fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_shift   <= '0;
      r_rspData <= '0;
      r_rspErr  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        if (!w_reqInRange) begin
          r_rspData <= 8'h00;
          r_rspErr  <= 1'b1;
        end
      end
      if (r_state == XFER) begin
        r_shift <= w_captured;
        if (w_bit == 3'd7) begin
          r_rspData <= r_we ? r_wdata : w_captured;
          r_rspErr  <= 1'b0;
        end
      end
    end
  end

  assign rsp_rdata = r_rspData;
  assign rsp_err   = r_rspErr;

endmodule

// File: tb/tb_option22_seq_ctrl.sv
// Scoreboard bench for option22_seq_ctrl: one 64-word instance backed by a
// behavioural recirculating memory, and one 48-word instance for the
// out-of-range path.
module tb_option22_seq_ctrl;

  localparam int CL1 = 512;
  localparam int CL2 = 384;

  typedef struct {
    logic        err;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       reqValid, reqWe, reqReady, rspValid, rspErr, memWrite, memDin, memDout;
  logic [5:0] reqAddr;
  logic [7:0] reqWdata, rspRdata;
  logic [8:0] pos;

  logic       reqValid2, reqWe2, reqReady2, rspValid2, rspErr2, memWrite2, memDin2, memDout2;
  logic [5:0] reqAddr2;
  logic [7:0] reqWdata2, rspRdata2;
  logic [8:0] pos2;

  int unsigned cyc = 0;
  logic        memBits [0:CL1-1] = '{default: 1'b0};
  logic [7:0]  expWords [0:63] = '{default: 8'h00};
  exp_t        q1 [$];
  exp_t        q2 [$];
  int          checks = 0;
  int          errors = 0;
  bit          d2WriteSeen = 1'b0;

  option22_seq_ctrl #(.WORD_COUNT(64), .ADDR_W(6)) dut (
    .clk(clk), .reset(reset),
    .req_valid(reqValid), .req_ready(reqReady), .req_we(reqWe),
    .req_addr(reqAddr), .req_wdata(reqWdata),
    .rsp_valid(rspValid), .rsp_err(rspErr), .rsp_rdata(rspRdata),
    .mem_write(memWrite), .mem_din(memDin), .mem_dout(memDout), .pos(pos)
  );

  option22_seq_ctrl #(.WORD_COUNT(48), .ADDR_W(6)) dut2 (
    .clk(clk), .reset(reset),
    .req_valid(reqValid2), .req_ready(reqReady2), .req_we(reqWe2),
    .req_addr(reqAddr2), .req_wdata(reqWdata2),
    .rsp_valid(rspValid2), .rsp_err(rspErr2), .rsp_rdata(rspRdata2),
    .mem_write(memWrite2), .mem_din(memDin2), .mem_dout(memDout2), .pos(pos2)
  );

  always #5 clk = ~clk;

  // Bench cycle count; cycle 0 is the first cycle after reset release.
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  // Behavioural shift memory indexed by rotation position.
  assign memDout  = memBits[cyc % CL1];
  assign memDout2 = 1'b0;
  always @(posedge clk) if (!reset && memWrite) memBits[cyc % CL1] <= memDin;

  // Any pin activity on the 48-word instance is unexpected.
  always @(negedge clk) if (memWrite2 || memDin2) d2WriteSeen = 1'b1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int unsigned respCycle(input int unsigned t, input int addr, input int cl);
    int p1, s;
    p1 = int'((t + 1) % cl);
    s  = ((8 * addr - p1) % cl + cl) % cl;
    return t + 1 + s + 8;
  endfunction

  // Issue one request (sel picks the instance) at a negedge and queue its expected response.
  task automatic applyStimulus(input bit sel, input bit we, input int addr,
                               input logic [7:0] wdata, input bit err);
    exp_t e;
    int   n = 0;
    while (!(sel ? reqReady2 : reqReady) && n < 1200) begin
      @(negedge clk);
      n++;
    end
    if (!(sel ? reqReady2 : reqReady)) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready timeout: req_ready still 0 after %0d cycles, expected 1", n);
      return;
    end
    e.err  = err;
    e.cyc  = err ? cyc + 1 : respCycle(cyc, addr, sel ? CL2 : CL1);
    e.data = err ? 8'h00 : (we ? wdata : (sel ? 8'h00 : expWords[addr]));
    if (!sel && we && !err) expWords[addr] = wdata;
    if (sel) begin
      reqValid2 = 1'b1; reqWe2 = we; reqAddr2 = 6'(addr); reqWdata2 = wdata;
      q2.push_back(e);
    end else begin
      reqValid = 1'b1; reqWe = we; reqAddr = 6'(addr); reqWdata = wdata;
      q1.push_back(e);
    end
    @(negedge clk);
    reqValid = 1'b0; reqValid2 = 1'b0;
    reqAddr = 6'h2a; reqAddr2 = 6'h3f; reqWdata = 8'hee; reqWdata2 = 8'hee;
  endtask

  // Monitor: pop and compare whenever either instance pulses rsp_valid.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (rspValid) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL dut unexpected rsp_valid: got 1, expected 0 (cycle %0d)", cyc);
        end else begin
          e = q1.pop_front();
          checkOutput("dut rsp cycle", cyc, e.cyc);
          checkOutput("dut rsp_err", 32'(rspErr), 32'(e.err));
          checkOutput("dut rsp_rdata", 32'(rspRdata), 32'(e.data));
          checkOutput("dut pos at rsp", 32'(pos), e.cyc % CL1);
        end
      end
      if (rspValid2) begin
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL dut2 unexpected rsp_valid: got 1, expected 0 (cycle %0d)", cyc);
        end else begin
          e = q2.pop_front();
          checkOutput("dut2 rsp cycle", cyc, e.cyc);
          checkOutput("dut2 rsp_err", 32'(rspErr2), 32'(e.err));
          checkOutput("dut2 rsp_rdata", 32'(rspRdata2), 32'(e.data));
          checkOutput("dut2 pos at rsp", 32'(pos2), e.cyc % CL2);
        end
      end
    end
  end

  // Directed sequence.
  initial begin
    logic [7:0] pat;
    logic       expW;
    int         n;
    reqValid = 0; reqWe = 0; reqAddr = 0; reqWdata = 0;
    reqValid2 = 0; reqWe2 = 0; reqAddr2 = 0; reqWdata2 = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    checkOutput("reset pos", 32'(pos), 0);
    checkOutput("reset req_ready", 32'(reqReady), 1);
    checkOutput("reset rsp_valid", 32'(rspValid), 0);
    checkOutput("reset rsp_err", 32'(rspErr), 0);
    checkOutput("reset rsp_rdata", 32'(rspRdata), 0);
    checkOutput("reset mem_write", 32'(memWrite), 0);
    checkOutput("reset mem_din", 32'(memDin), 0);
    checkOutput("reset dut2 req_ready", 32'(reqReady2), 1);

    // Write 0xA5 to word 3 accepted at cycle 0: pins active in cycles 24..31.
    pat = 8'hA5;
    applyStimulus(0, 1, 3, 8'hA5, 0);
    while (cyc <= 33) begin
      expW = (cyc >= 24 && cyc <= 31);
      checkOutput("write window mem_write", 32'(memWrite), 32'(expW));
      if (expW) checkOutput("write window mem_din", 32'(memDin), 32'(pat[7 - (cyc - 24)]));
      else      checkOutput("idle mem_din", 32'(memDin), 0);
      @(negedge clk);
    end

    // Neighbour write, then read both back.
    applyStimulus(0, 1, 4, 8'h3C, 0);
    applyStimulus(0, 0, 3, 8'h00, 0);
    applyStimulus(0, 0, 4, 8'h00, 0);

    // Reset in the middle of a write, at bit j=4.
    applyStimulus(0, 1, 5, 8'h5A, 0);
    n = 0;
    while (!memWrite && n < 1200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checkOutput("mid-write mem_write at j4", 32'(memWrite), 1);
    reset = 1'b1;
    q1.delete();
    @(negedge clk);
    checkOutput("abort pos", 32'(pos), 0);
    checkOutput("abort req_ready", 32'(reqReady), 1);
    checkOutput("abort rsp_valid", 32'(rspValid), 0);
    checkOutput("abort rsp_err", 32'(rspErr), 0);
    checkOutput("abort rsp_rdata", 32'(rspRdata), 0);
    checkOutput("abort mem_write", 32'(memWrite), 0);
    checkOutput("abort mem_din", 32'(memDin), 0);
    reset = 1'b0;

    // Full rotation: read word 0 accepted at pos 0 responds at cycle 520.
    applyStimulus(0, 0, 0, 8'h00, 0);
    applyStimulus(0, 0, 3, 8'h00, 0);

    // Boundary words across the 511 -> 0 wrap.
    applyStimulus(0, 1, 63, 8'hFF, 0);
    applyStimulus(0, 1, 0, 8'h00, 0);
    applyStimulus(0, 0, 63, 8'h00, 0);
    applyStimulus(0, 0, 0, 8'h00, 0);

    // 48-word instance: out-of-range requests and the last valid word.
    applyStimulus(1, 0, 50, 8'h00, 1);
    applyStimulus(1, 1, 48, 8'h77, 1);
    applyStimulus(1, 0, 47, 8'h00, 0);

    n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (q1.size() != 0 || q2.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL response timeout: %0d responses outstanding, expected 0", q1.size() + q2.size());
    end
    checkOutput("dut2 no memory activity", 32'(d2WriteSeen), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
